// File: rtl/ps2io_pkg.sv
// Shared definitions for the PS/2 keyboard receiver: register map, bit
// positions and the receiver state encoding.
`timescale 1ns/1ps
package ps2io_pkg;
  localparam logic [1:0] REG_DATA   = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_CTRL   = 2'd2;
  localparam logic [1:0] REG_COUNT  = 2'd3;

  localparam int ST_NE   = 0;
  localparam int ST_FULL = 1;
  localparam int ST_OVR  = 2;
  localparam int ST_PERR = 3;
  localparam int ST_FERR = 4;
  localparam int ST_IRQ  = 7;

  localparam int CT_IRQ_EN = 0;
  localparam int CT_RX_EN  = 1;
  localparam int CT_FLUSH  = 7;

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} rx_state_t;
endpackage

// File: rtl/ps2_rx.sv
// PS/2 frame deserialiser: synchronises the lines, detects falling clock
// edges and assembles start/8 data/odd parity/stop frames into bytes.
`timescale 1ns/1ps
module ps2_rx
  import ps2io_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 2000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_en,
  input  logic       ps2clk,
  input  logic       ps2dat,
  output logic [7:0] data_byte,
  output logic       byte_valid,
  output logic       parity_err_pulse,
  output logic       frame_err_pulse
);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  logic [1:0]    clk_sync, dat_sync;
  logic          clk_prev, fall, dat;
  rx_state_t     state;
  logic [2:0]    bit_cnt;
  logic [7:0]    shreg;
  logic          par;
  logic [TW-1:0] tmo;

  // Lines idle high, so the synchroniser resets to 1 to avoid a false edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clk_sync <= 2'b11;
      dat_sync <= 2'b11;
      clk_prev <= 1'b1;
    end else begin
      clk_sync <= {clk_sync[0], ps2clk};
      dat_sync <= {dat_sync[0], ps2dat};
      clk_prev <= clk_sync[1];
    end
  end

  assign fall = clk_prev & ~clk_sync[1];
  assign dat  = dat_sync[1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state            <= IDLE;
      bit_cnt          <= '0;
      shreg            <= '0;
      par              <= 1'b0;
      tmo              <= '0;
      data_byte        <= '0;
      byte_valid       <= 1'b0;
      parity_err_pulse <= 1'b0;
      frame_err_pulse  <= 1'b0;
    end else begin
      byte_valid       <= 1'b0;
      parity_err_pulse <= 1'b0;
      frame_err_pulse  <= 1'b0;
      if (!rx_en) begin
        state <= IDLE;
        tmo   <= '0;
      end else if (fall) begin
        tmo <= '0;
        case (state)
          IDLE: if (!dat) begin
            state   <= DATA;
            bit_cnt <= '0;
          end
          DATA: begin
            shreg   <= {dat, shreg[7:1]};
            bit_cnt <= bit_cnt + 1'b1;
            if (bit_cnt == 3'd7) state <= PARITY;
          end
          PARITY: begin
            par   <= dat;
            state <= STOP;
          end
          STOP: begin
            state <= IDLE;
            if (!dat) frame_err_pulse <= 1'b1;
            else if (!(^{par, shreg})) parity_err_pulse <= 1'b1;
            else begin
              data_byte  <= shreg;
              byte_valid <= 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end else if (state != IDLE) begin
        // A stalled keyboard must not wedge the receiver mid-frame.
        if (tmo == TMO_LAST) begin
          state           <= IDLE;
          tmo             <= '0;
          frame_err_pulse <= 1'b1;
        end else begin
          tmo <= tmo + 1'b1;
        end
      end
    end
  end
endmodule

// File: rtl/ps2io.sv
// Bus-mapped PS/2 receiver: receive FIFO, DATA/STATUS/CTRL/COUNT registers,
// deferred pop on read and level irq.
`timescale 1ns/1ps
module ps2io
  import ps2io_pkg::*;
#(
  parameter int FIFO_DEPTH     = 8,
  parameter int TIMEOUT_CYCLES = 2000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] AD,
  input  logic [7:0] DI,
  output logic [7:0] DO,
  input  logic       rw,
  input  logic       cs,
  output logic       irq,
  input  logic       ps2clk,
  input  logic       ps2dat
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(FIFO_DEPTH);

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          irq_en, rx_en, ovr, perr, ferr, rd_q;
  logic [7:0]    rx_byte;
  logic          rx_valid, rx_perr, rx_ferr;
  logic          empty, full, wr, wr_stat, rd_acc, flush, pop, push, ovr_set;
  logic [7:0]    status;
  logic          unused_di;

  ps2_rx #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_rx (
    .clk              (clk),
    .rst              (rst),
    .rx_en            (rx_en),
    .ps2clk           (ps2clk),
    .ps2dat           (ps2dat),
    .data_byte        (rx_byte),
    .byte_valid       (rx_valid),
    .parity_err_pulse (rx_perr),
    .frame_err_pulse  (rx_ferr)
  );

  assign empty   = (count == '0);
  assign full    = (count == DEPTH_C);
  assign wr      = cs & ~rw;
  assign wr_stat = wr & (AD == REG_STATUS);
  assign rd_acc  = cs & rw & (AD == REG_DATA);
  assign flush   = wr & (AD == REG_CTRL) & DI[CT_FLUSH];
  // Pop once the access has ended so DO holds steady for the whole read.
  assign pop     = rd_q & ~rd_acc & ~empty & ~flush;
  assign push    = rx_valid & (~full | pop) & ~flush;
  assign ovr_set = rx_valid & full & ~pop & ~flush;
  assign unused_di = ^DI[6:5];

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= rx_byte;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      rd_q   <= 1'b0;
      irq_en <= 1'b0;
      rx_en  <= 1'b1;
      ovr    <= 1'b0;
      perr   <= 1'b0;
      ferr   <= 1'b0;
      irq    <= 1'b0;
    end else begin
      rd_q <= rd_acc & ~empty;
      irq  <= irq_en & (~empty | ovr | perr | ferr);
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (pop)  rd_ptr <= rd_ptr + 1'b1;
        if (push && !pop)      count <= count + 1'b1;
        else if (pop && !push) count <= count - 1'b1;
      end
      if (wr && AD == REG_CTRL) begin
        irq_en <= DI[CT_IRQ_EN];
        rx_en  <= DI[CT_RX_EN];
      end
      // A new event in the same cycle as a clear wins, so it is never lost.
      ovr  <= ovr_set | (ovr  & ~(wr_stat & DI[ST_OVR]));
      perr <= rx_perr | (perr & ~(wr_stat & DI[ST_PERR]));
      ferr <= rx_ferr | (ferr & ~(wr_stat & DI[ST_FERR]));
    end
  end

  always_comb begin
    status          = '0;
    status[ST_NE]   = ~empty;
    status[ST_FULL] = full;
    status[ST_OVR]  = ovr;
    status[ST_PERR] = perr;
    status[ST_FERR] = ferr;
    status[ST_IRQ]  = irq;
  end

  always_comb begin
    DO = '0;
    case (AD)
      REG_DATA:   DO = empty ? 8'h00 : mem[rd_ptr];
      REG_STATUS: DO = status;
      REG_CTRL:   DO = {6'b0, rx_en, irq_en};
      REG_COUNT:  DO = 8'(count);
      default:    DO = '0;
    endcase
  end
endmodule

// File: doc/ps2io.md
# ps2io

Bus-mapped PS/2 keyboard receiver for the superio peripheral window. It deserialises PS2CLK/PS2DAT frames into bytes and buffers them in a small FIFO. It presents data and status to the HD6303 through the same cs/rw/AD/DI/DO register interface as simpleio and spiio, and raises an active-high irq that the superio top inverts onto IRQ[1].

## Interface
- FIFO_DEPTH, 8: receive FIFO entries; power of two, 2..16.
- TIMEOUT_CYCLES, 2000: clk cycles without a PS/2 falling edge before a partial frame is abandoned (2 ms at 1 MHz E).
- clk  in  1  bus clock (E); the only clock in the block; all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- AD  in  2  register select.
- DI  in  8  write data.
- DO  out  8  read data; combinational from AD and current state.
- rw  in  1  1 = read, 0 = write.
- cs  in  1  block select, active-high.
- irq  out  1  active-high interrupt request.
- ps2clk  in  1  PS/2 clock line, asynchronous.
- ps2dat  in  1  PS/2 data line, asynchronous.

## Operation
Registers:
- AD=0 DATA: reading returns the FIFO head, or 0x00 if the FIFO is empty. The head is popped once per read access. Writes are ignored.
- AD=1 STATUS: bit0 = not empty, bit1 = full, bit2 = overrun, bit3 = parity error, bit4 = frame error, bit7 = irq. Writing 1 to bits 2–4 clears those bits; other bits are read-only.
- AD=2 CTRL: bit0 = irq enable, bit1 = rx enable. Bit7 = flush: empties the FIFO, is self-clearing, and always reads 0.
- AD=3 COUNT: FIFO occupancy, 0..FIFO_DEPTH. Read-only.

Write access: cs && !rw, sampled on clk.

Pop rule: a read access is cs && rw && AD==0. The pop happens on the first clk edge where the registered read flag is 1 and the current read is 0. This makes the pop one cycle after the access ends, so DO stays stable for the whole access. Reading an empty FIFO does not pop.

Receiver:
- Input path: ps2clk and ps2dat each pass through a 2-FF synchroniser. A falling edge is synchronised ps2clk going 1→0. Data is sampled on that edge.
- IDLE: wait for a falling edge with data = 0 (start bit). A start bit of 1 is ignored. Go to DATA with the bit counter at 0.
- DATA: shift in 8 bits, LSB first. After bit 7, go to PARITY.
- PARITY: store the parity bit. Go to STOP.
- STOP: if stop = 0, set frame error and discard the byte. Else if the 9 bits have even total parity (odd-parity failure), set parity error and discard. Otherwise push the byte. Return to IDLE in all cases.
- Timeout: outside IDLE, a cycle counter resets on every falling edge. If it reaches TIMEOUT_CYCLES, go to IDLE, set frame error, discard the byte.
- rx enable = 0: force IDLE and ignore edges. A frame in progress is dropped silently, with no error flag.

FIFO:
- Push while full: byte dropped, overrun set, contents unchanged.
- Pop and push in the same cycle: both take effect, count unchanged. This applies when full too: no overrun.
- Flush in the same cycle as a push: flush wins, count = 0.
- Pointers wrap modulo FIFO_DEPTH.
- Count is log2(FIFO_DEPTH)+1 bits wide.

irq = irq enable && (not empty || overrun || parity error || frame error).

## Timing
- Reset values: DO follows its combinational rule, so it reads 0x00 when AD=0 because the FIFO is empty. irq = 0, FIFO empty, all flags 0, CTRL = 0x02 (rx enabled, irq disabled), receiver in IDLE.
- Synchroniser plus edge detect adds 3 clk cycles from a PS/2 edge to the internal sample.
- Push happens in the cycle after the stop bit is sampled. Not-empty and irq update one cycle after that.
- The pop takes effect one clk after the end of the read access. Status and count reflect it on the following cycle.
- Register writes take effect on the sampling edge. irq updates on the next cycle.
- Minimum requirement: clk ≥ 8× the PS/2 clock (≥ 140 kHz for 16.7 kHz PS/2).
- Reset asserted mid-frame aborts immediately. After reset release, the next valid start bit is received normally.

## Structure
- Package ps2io_pkg contains: register offsets, STATUS/CTRL bit indices, and the receiver state enum (IDLE, DATA, PARITY, STOP).
- Sub-module ps2_rx contains the synchroniser, edge detect, state machine and timeout counter. It outputs byte[7:0], byte_valid (1-cycle pulse), parity_err_pulse and frame_err_pulse.
- The top of ps2io contains the FIFO, registers, pop logic and irq.

## Test plan
- Valid frame: send 0x1C (bits 0,0,1,1,1,0,0,0; parity 0; stop 1) at 12.5 kHz with clk = 1 MHz. Expect COUNT=1 and STATUS=0x01. With CTRL=0x03, irq=1. Reading DATA returns 0x1C; after the pop, COUNT=0 and irq=0.
- Parity error: send 0x1C with parity bit 1. Expect COUNT=0 and STATUS bit3=1. Write 0x08 to STATUS; expect STATUS=0x00.
- Overrun: send 9 valid bytes 0x01..0x09 with no reads. Expect COUNT=8, STATUS=0x07, and reads returning 0x01..0x08. Simultaneous pop and push at full: no overrun.
- Timeout and recovery: send a start bit plus 4 data bits, then hold ps2clk high for 2000 cycles. Expect frame error and an idle receiver. A following 0xF0 frame (parity 1) is received correctly.
- Flush and reset: fill 3 bytes, write 0x82 to CTRL. Expect COUNT=0 and CTRL to read 0x02. Assert rst mid-frame: all outputs take their reset values, and the next full frame is received correctly.
